// File: rtl/posit_result_arbiter.sv
// Round-robin merge of posit slice result channels onto one registered output port.
// A one-entry output register decouples slice back-pressure from writeback timing.
package posit_pkg;
    typedef struct packed {
        logic nv;
        logic dz;
        logic of;
        logic uf;
        logic nx;
    } status_t;
endpackage

module posit_result_arbiter #(
    parameter int unsigned NumInputs = 2,
    parameter int unsigned Width     = 32,
    parameter int unsigned TagWidth  = 1,
    localparam int unsigned SrcWidth = (NumInputs > 1) ? $clog2(NumInputs) : 1
) (
    input  logic                                 clk_i,
    input  logic                                 rst_i,
    input  logic [NumInputs-1:0]                 in_valid_i,
    output logic [NumInputs-1:0]                 in_ready_o,
    input  logic [NumInputs-1:0][Width-1:0]      in_result_i,
    input  posit_pkg::status_t [NumInputs-1:0]   in_status_i,
    input  logic [NumInputs-1:0]                 in_ext_bit_i,
    input  logic [NumInputs-1:0][TagWidth-1:0]   in_tag_i,
    input  logic [NumInputs-1:0]                 in_busy_i,
    input  logic                                 flush_i,
    output logic                                 out_valid_o,
    input  logic                                 out_ready_i,
    output logic [Width-1:0]                     result_o,
    output posit_pkg::status_t                   status_o,
    output logic                                 extension_bit_o,
    output logic [TagWidth-1:0]                  tag_o,
    output logic [SrcWidth-1:0]                  src_o,
    output logic                                 busy_o
);

    localparam logic [SrcWidth:0]   NumInW  = (SrcWidth+1)'(NumInputs);
    localparam logic [SrcWidth-1:0] LastIdx = SrcWidth'(NumInputs - 1);

    logic                   full_q, full_d;
    logic [SrcWidth-1:0]    rr_ptr_q, rr_ptr_d;
    logic [Width-1:0]       result_q, result_d;
    posit_pkg::status_t     status_q, status_d;
    logic                   ext_q, ext_d;
    logic [TagWidth-1:0]    tag_q, tag_d;
    logic [SrcWidth-1:0]    src_q, src_d;

    logic                   load_en;
    logic                   found;
    logic                   transfer;
    logic [SrcWidth-1:0]    gnt_idx;
    logic [SrcWidth:0]      scan;
    logic [NumInputs-1:0]   grant;

    always_comb begin
        load_en = ~rst_i & ~flush_i & (~full_q | out_ready_i);
        grant   = '0;
        found   = 1'b0;
        gnt_idx = '0;
        scan    = '0;
        // Scan from rr_ptr upward, wrapping, and take the first valid slice.
        for (int i = 0; i < int'(NumInputs); i++) begin
            scan = {1'b0, rr_ptr_q} + (SrcWidth+1)'(i);
            if (scan >= NumInW) begin
                scan = scan - NumInW;
            end
            if (!found && in_valid_i[scan[SrcWidth-1:0]]) begin
                found   = 1'b1;
                gnt_idx = scan[SrcWidth-1:0];
                grant[scan[SrcWidth-1:0]] = 1'b1;
            end
        end
        in_ready_o = grant & {NumInputs{load_en}};
        transfer   = load_en & found;

        full_d   = full_q;
        rr_ptr_d = rr_ptr_q;
        result_d = result_q;
        status_d = status_q;
        ext_d    = ext_q;
        tag_d    = tag_q;
        src_d    = src_q;

        if (flush_i) begin
            full_d = 1'b0;
        end else if (transfer) begin
            full_d   = 1'b1;
            rr_ptr_d = (gnt_idx == LastIdx) ? '0 : gnt_idx + SrcWidth'(1);
            result_d = in_result_i[gnt_idx];
            status_d = in_status_i[gnt_idx];
            ext_d    = in_ext_bit_i[gnt_idx];
            tag_d    = in_tag_i[gnt_idx];
            src_d    = gnt_idx;
        end else if (out_ready_i) begin
            full_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            full_q   <= 1'b0;
            rr_ptr_q <= '0;
            result_q <= '0;
            status_q <= '0;
            ext_q    <= 1'b0;
            tag_q    <= '0;
            src_q    <= '0;
        end else begin
            full_q   <= full_d;
            rr_ptr_q <= rr_ptr_d;
            result_q <= result_d;
            status_q <= status_d;
            ext_q    <= ext_d;
            tag_q    <= tag_d;
            src_q    <= src_d;
        end
    end

    assign out_valid_o     = full_q;
    assign result_o        = result_q;
    assign status_o        = status_q;
    assign extension_bit_o = ext_q;
    assign tag_o           = tag_q;
    assign src_o           = src_q;
    assign busy_o          = full_q | (|in_busy_i);

endmodule

// File: tb/tb_posit_result_arbiter.sv
// Bench for posit_result_arbiter: directed scenarios with literal expectations,
// then random traffic, all shadowed by a cycle-level behavioural model.
module tb_posit_result_arbiter;
    localparam int N  = 2;
    localparam int W  = 32;
    localparam int TW = 1;
    localparam int SW = 1;

    logic clk = 1'b0;
    logic rst_i;
    logic [N-1:0] in_valid, in_ready, in_ext, in_busy;
    logic [N-1:0][W-1:0] in_result;
    posit_pkg::status_t [N-1:0] in_status;
    logic [N-1:0][TW-1:0] in_tag;
    logic flush, out_valid, out_ready, ext_o, busy_o;
    logic [W-1:0] result_o;
    posit_pkg::status_t status_o;
    logic [TW-1:0] tag_o;
    logic [SW-1:0] src_o;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    posit_result_arbiter #(.NumInputs(N), .Width(W), .TagWidth(TW)) dut (
        .clk_i(clk), .rst_i(rst_i),
        .in_valid_i(in_valid), .in_ready_o(in_ready),
        .in_result_i(in_result), .in_status_i(in_status),
        .in_ext_bit_i(in_ext), .in_tag_i(in_tag), .in_busy_i(in_busy),
        .flush_i(flush), .out_valid_o(out_valid), .out_ready_i(out_ready),
        .result_o(result_o), .status_o(status_o), .extension_bit_o(ext_o),
        .tag_o(tag_o), .src_o(src_o), .busy_o(busy_o)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // First valid index scanning upward from ptr with wraparound, -1 if none.
    function automatic int pick(input logic [N-1:0] v, input int ptr);
        for (int i = 0; i < N; i++) begin
            int k;
            k = (ptr + i) % N;
            if (v[k]) return k;
        end
        return -1;
    endfunction

    // Behavioural model: output register contents plus fairness pointer.
    bit m_on = 1'b0;
    bit m_full;
    int m_ptr;
    logic [W-1:0] m_res;
    logic [4:0] m_stat;
    logic m_ext;
    logic [TW-1:0] m_tag;
    int m_src;
    logic [N-1:0] last_hs = '0;

    always @(negedge clk) begin
        int k;
        logic [N-1:0] exp_rdy;
        k = pick(in_valid, m_ptr);
        exp_rdy = '0;
        if (!rst_i && !flush && (!m_full || out_ready) && k >= 0) exp_rdy[k] = 1'b1;
        last_hs = in_valid & in_ready;
        if (m_on) begin
            chk("m_in_ready", in_ready, exp_rdy);
            chk("m_out_valid", out_valid, m_full);
            chk("m_result", result_o, m_res);
            chk("m_status", status_o, m_stat);
            chk("m_ext", ext_o, m_ext);
            chk("m_tag", tag_o, m_tag);
            chk("m_src", src_o, m_src);
            chk("m_busy", busy_o, m_full | (|in_busy));
        end
        if (rst_i) begin
            m_on = 1'b1; m_full = 1'b0; m_ptr = 0; m_res = '0; m_stat = '0;
            m_ext = 1'b0; m_tag = '0; m_src = 0;
        end else if (flush) begin
            m_full = 1'b0;
        end else if (exp_rdy != '0) begin
            m_res  = in_result[k];
            m_stat = in_status[k];
            m_ext  = in_ext[k];
            m_tag  = in_tag[k];
            m_src  = k;
            m_full = 1'b1;
            m_ptr  = (k + 1) % N;
        end else if (out_ready) begin
            m_full = 1'b0;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_i = 1'b1; flush = 1'b0; out_ready = 1'b0;
        in_valid = 2'b11; in_busy = '0; in_ext = '0; in_tag = '0; in_status = '0;
        in_result[0] = 32'hDEAD_0000; in_result[1] = 32'hBEEF_0000;
        step(); step(); #1;
        chk("rst_valid", out_valid, 0);
        chk("rst_result", result_o, 0);
        chk("rst_src", src_o, 0);
        chk("rst_ready", in_ready, 2'b00);
        rst_i = 1'b0; in_valid = 2'b00;
        step();

        // Single slice latency
        in_valid = 2'b01; in_result[0] = 32'h4000_0000; in_tag[0] = 1'b1; out_ready = 1'b1;
        #1; chk("single_ready", in_ready, 2'b01);
        step(); in_valid = 2'b00; #1;
        chk("single_valid", out_valid, 1);
        chk("single_result", result_o, 32'h4000_0000);
        chk("single_tag", tag_o, 1);
        chk("single_src", src_o, 0);
        step(); #1;
        chk("single_pop", out_valid, 0);

        // Round-robin fairness
        rst_i = 1'b1; step(); rst_i = 1'b0;
        in_valid = 2'b11; in_result[0] = 32'hA0; in_result[1] = 32'hB0; out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step(); #1;
            chk("rr_src", src_o, i % 2);
            chk("rr_valid", out_valid, 1);
        end
        in_valid = 2'b00; step();

        // Back-pressure
        rst_i = 1'b1; step(); rst_i = 1'b0;
        in_valid = 2'b11; in_result[0] = 32'h111; in_result[1] = 32'h222; out_ready = 1'b0;
        #1; chk("bp_ready0", in_ready, 2'b01);
        step(); in_result[0] = 32'h333;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("bp_stall_ready", in_ready, 2'b00);
            chk("bp_hold", result_o, 32'h111);
            chk("bp_valid", out_valid, 1);
            step();
        end
        out_ready = 1'b1; #1;
        chk("bp_release_ready", in_ready, 2'b10);
        step(); in_valid = 2'b01; #1;
        chk("bp_drain1", result_o, 32'h222);
        chk("bp_drain1_src", src_o, 1);
        chk("bp_ready_next", in_ready, 2'b01);
        step(); in_valid = 2'b00; #1;
        chk("bp_drain2", result_o, 32'h333);
        chk("bp_drain2_src", src_o, 0);
        step(); #1;
        chk("bp_empty", out_valid, 0);

        // Flush
        rst_i = 1'b1; step(); rst_i = 1'b0;
        in_valid = 2'b01; in_result[0] = 32'h1234_5678; out_ready = 1'b0;
        step();
        in_valid = 2'b11; in_result[0] = 32'h55; in_result[1] = 32'h66; flush = 1'b1;
        #1;
        chk("fl_ready", in_ready, 2'b00);
        chk("fl_full_before", out_valid, 1);
        step(); flush = 1'b0; #1;
        chk("fl_valid", out_valid, 0);
        chk("fl_result_kept", result_o, 32'h1234_5678);
        chk("fl_ptr_kept", in_ready, 2'b10);
        step(); #1;
        chk("fl_next_src", src_o, 1);
        chk("fl_next_result", result_o, 32'h66);
        in_valid = 2'b00; out_ready = 1'b1;
        step(); step();

        // Reset mid-stream
        in_valid = 2'b01; in_result[0] = 32'h9999; out_ready = 1'b0;
        step();
        rst_i = 1'b1; in_valid = 2'b00;
        step();
        rst_i = 1'b0; in_valid = 2'b11; #1;
        chk("rm_valid", out_valid, 0);
        chk("rm_src", src_o, 0);
        chk("rm_result", result_o, 0);
        chk("rm_grant", in_ready, 2'b01);
        step(); in_valid = 2'b00; out_ready = 1'b1;
        step();

        // Busy
        in_busy = 2'b10; #1;
        chk("busy_slice", busy_o, 1);
        in_busy = 2'b00; in_valid = 2'b01; out_ready = 1'b0;
        step(); in_valid = 2'b00; #1;
        chk("busy_full", busy_o, 1);
        out_ready = 1'b1;
        step(); #1;
        chk("busy_idle", busy_o, 0);
        chk("busy_idle_valid", out_valid, 0);

        // Random traffic; slices hold valid and data until accepted
        for (int c = 0; c < 3000; c++) begin
            for (int k = 0; k < N; k++) begin
                if (!in_valid[k] || last_hs[k]) begin
                    in_valid[k]  = ($urandom % 3) != 0;
                    in_result[k] = $urandom;
                    in_status[k] = 5'($urandom);
                    in_ext[k]    = 1'($urandom);
                    in_tag[k]    = TW'($urandom);
                end
            end
            out_ready = ($urandom % 4) != 0;
            flush     = ($urandom % 30) == 0;
            rst_i     = ($urandom % 150) == 0;
            in_busy   = N'($urandom);
            step();
        end
        in_valid = '0; flush = 1'b0; rst_i = 1'b0; out_ready = 1'b1;
        step(); step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
